// File: rtl/rab_sched_pkg.sv
// Shared types for the RAB lookup scheduler.
// Response status codes, FSM states and the result classifier.
package rab_sched_pkg;

   typedef enum logic [1:0] {
      ST_OK    = 2'b00,
      ST_MISS  = 2'b01,
      ST_PROT  = 2'b10,
      ST_MULTI = 2'b11
   } rsp_status_t;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      RESP
   } sched_state_t;

   // A multi-hit outranks a permitted hit, which outranks a denied match.
   function automatic rsp_status_t classify(
      input logic multi,
      input logic hit,
      input logic prot
   );
      if (multi) return ST_MULTI;
      if (hit) return ST_OK;
      if (prot) return ST_PROT;
      return ST_MISS;
   endfunction

endpackage

// File: rtl/rab_lookup_sched_if.sv
// Request/response, lookup bus, config and counter signals
// of the RAB lookup scheduler.
interface rab_lookup_sched_if #(
   parameter int NUM_REQ     = 4,
   parameter int RAB_ENTRIES = 16,
   parameter int ADDR_WIDTH  = 32,
   parameter int CNT_WIDTH   = 16
);
   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0]                 req_ready;
   logic [NUM_REQ-1:0]                 req_rw;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_min;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_max;

   logic                               lk_rw;
   logic [ADDR_WIDTH-1:0]              lk_addr_min;
   logic [ADDR_WIDTH-1:0]              lk_addr_max;
   logic [RAB_ENTRIES-1:0]             lk_hit;
   logic [RAB_ENTRIES-1:0]             lk_prot;
   logic                               lk_multi;
   logic                               lk_master_sel;
   logic [ADDR_WIDTH-1:0]              lk_out_addr;

   logic [NUM_REQ-1:0]                 rsp_valid;
   logic [NUM_REQ-1:0]                 rsp_ready;
   logic [ADDR_WIDTH-1:0]              rsp_addr;
   logic                               rsp_master_sel;
   logic [1:0]                         rsp_status;

   logic                               cfg_busy;
   logic                               sched_idle;
   logic                               cnt_clr;
   logic [CNT_WIDTH-1:0]               miss_cnt;
   logic [CNT_WIDTH-1:0]               prot_cnt;

   modport slave (
      input  req_valid, req_rw, req_addr_min, req_addr_max,
      output req_ready,
      output lk_rw, lk_addr_min, lk_addr_max,
      input  lk_hit, lk_prot, lk_multi, lk_master_sel, lk_out_addr,
      output rsp_valid, rsp_addr, rsp_master_sel, rsp_status,
      input  rsp_ready,
      input  cfg_busy, cnt_clr,
      output sched_idle, miss_cnt, prot_cnt
   );

   modport master (
      output req_valid, req_rw, req_addr_min, req_addr_max,
      input  req_ready,
      input  lk_rw, lk_addr_min, lk_addr_max,
      output lk_hit, lk_prot, lk_multi, lk_master_sel, lk_out_addr,
      input  rsp_valid, rsp_addr, rsp_master_sel, rsp_status,
      output rsp_ready,
      output cfg_busy, cnt_clr,
      input  sched_idle, miss_cnt, prot_cnt
   );

endinterface

// File: rtl/rab_rr_arbiter.sv
// Combinational round-robin pick: first set request at or
// above ptr, wrapping modulo NUM_REQ.
module rab_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      idx,
   output logic               any_valid
);

   assign any_valid = |req;

   // Scan from the farthest offset down so the nearest one wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         int j;
         j = int'(ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/rab_lookup_sched.sv
// Shares one slice-table lookup between NUM_REQ requesters:
// round-robin grant, one lookup cycle, registered response.
module rab_lookup_sched
   import rab_sched_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int RAB_ENTRIES = 16,
   parameter int ADDR_WIDTH  = 32,
   parameter int CNT_WIDTH   = 16
) (
   input logic               Clk_CI,
   input logic               Rst_RBI,
   rab_lookup_sched_if.slave bus
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   sched_state_t           state;
   logic [IW-1:0]          rr_ptr;
   logic [IW-1:0]          win_idx;
   logic [IW-1:0]          arb_idx;
   logic [NUM_REQ-1:0]     arb_gnt;
   logic                   arb_any;
   logic                   hs;
   logic                   grant;
   logic                   lat_rw;
   logic [ADDR_WIDTH-1:0]  lat_min;
   logic [ADDR_WIDTH-1:0]  lat_max;
   logic [RAB_ENTRIES-1:0] hit_v;
   logic [RAB_ENTRIES-1:0] prot_v;
   rsp_status_t            cls;
   rsp_status_t            st;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic                   r_msel;
   logic [CNT_WIDTH-1:0]   miss_q;
   logic [CNT_WIDTH-1:0]   prot_q;

   rab_rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_arb (
      .req      (bus.req_valid),
      .ptr      (rr_ptr),
      .gnt      (arb_gnt),
      .idx      (arb_idx),
      .any_valid(arb_any)
   );

   assign hit_v  = bus.lk_hit;
   assign prot_v = bus.lk_prot;
   assign cls    = classify(bus.lk_multi, |hit_v, |prot_v);

   assign hs    = (state == RESP) && bus.rsp_ready[win_idx];
   assign grant = ((state == IDLE) || hs) && !bus.cfg_busy && arb_any;

   assign bus.req_ready = grant ? arb_gnt : '0;
   assign bus.rsp_valid = (state == RESP) ? (ONE << win_idx) : '0;

   assign bus.lk_rw          = lat_rw;
   assign bus.lk_addr_min    = lat_min;
   assign bus.lk_addr_max    = lat_max;
   assign bus.rsp_addr       = r_addr;
   assign bus.rsp_master_sel = r_msel;
   assign bus.rsp_status     = st;
   assign bus.sched_idle     = (state == IDLE);
   assign bus.miss_cnt       = miss_q;
   assign bus.prot_cnt       = prot_q;

   always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         win_idx <= '0;
         lat_rw  <= 1'b0;
         lat_min <= '0;
         lat_max <= '0;
         st      <= ST_OK;
         r_addr  <= '0;
         r_msel  <= 1'b0;
         miss_q  <= '0;
         prot_q  <= '0;
      end else begin
         unique case (state)
            IDLE: if (grant) state <= LOOKUP;
            LOOKUP: begin
               st     <= cls;
               r_addr <= (cls == ST_OK) ? bus.lk_out_addr : '0;
               r_msel <= (cls == ST_OK) && bus.lk_master_sel;
               state  <= RESP;
            end
            RESP: if (hs) state <= grant ? LOOKUP : IDLE;
            default: state <= IDLE;
         endcase

         if (grant) begin
            lat_rw  <= bus.req_rw[arb_idx];
            lat_min <= bus.req_addr_min[arb_idx];
            lat_max <= bus.req_addr_max[arb_idx];
            win_idx <= arb_idx;
            rr_ptr  <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
         end

         // Clear wins over a same-cycle increment.
         if (bus.cnt_clr) begin
            miss_q <= '0;
            prot_q <= '0;
         end else if (hs) begin
            if (st == ST_MISS && !(&miss_q)) miss_q <= miss_q + 1'b1;
            if (st == ST_PROT && !(&prot_q)) prot_q <= prot_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rab_lookup_sched.sv
// Bench for rab_lookup_sched: directed scenarios plus random
// traffic against a transaction-level model.
module tb_rab_lookup_sched;
   import rab_sched_pkg::*;

   localparam int N  = 4;
   localparam int E  = 16;
   localparam int AW = 32;
   localparam int CW = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rab_lookup_sched_if #(
      .NUM_REQ(N), .RAB_ENTRIES(E), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
   ) bus ();

   rab_lookup_sched #(
      .NUM_REQ(N), .RAB_ENTRIES(E), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
   ) dut (
      .Clk_CI (clk),
      .Rst_RBI(rst_n),
      .bus    (bus)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                    nm, act, exp, $time);
   endtask

   // Transaction-level model: one outstanding lookup at a time.
   typedef struct {
      logic          rw;
      logic [AW-1:0] amin;
      logic [AW-1:0] amax;
   } req_t;

   bit            m_busy = 0;
   bit            m_done = 0;
   int            m_who  = 0;
   int            m_ptr  = 0;
   req_t          m_req;
   logic [1:0]    m_st   = 2'b00;
   logic [AW-1:0] m_addr = '0;
   logic          m_msel = 1'b0;
   int            m_miss = 0;
   int            m_prot = 0;

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   always @(negedge clk) begin
      int w;
      bit hs;
      bit g;
      logic [N-1:0] er;
      logic [N-1:0] ev;
      w  = pick(bus.req_valid, m_ptr);
      hs = m_done && bus.rsp_ready[m_who];
      g  = (!m_busy || hs) && !bus.cfg_busy && (w >= 0);
      er = '0;
      if (g) er[w] = 1'b1;
      ev = '0;
      if (m_done) ev[m_who] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
      chk("sched_idle", 64'(bus.sched_idle), 64'(!m_busy));
      chk("miss_cnt", 64'(bus.miss_cnt), 64'(m_miss));
      chk("prot_cnt", 64'(bus.prot_cnt), 64'(m_prot));
      if (m_busy && !m_done) begin
         chk("lk_rw", 64'(bus.lk_rw), 64'(m_req.rw));
         chk("lk_addr_min", 64'(bus.lk_addr_min), 64'(m_req.amin));
         chk("lk_addr_max", 64'(bus.lk_addr_max), 64'(m_req.amax));
      end
      if (m_done) begin
         chk("rsp_status", 64'(bus.rsp_status), 64'(m_st));
         chk("rsp_addr", 64'(bus.rsp_addr), 64'(m_addr));
         chk("rsp_msel", 64'(bus.rsp_master_sel), 64'(m_msel));
      end

      if (!rst_n) begin
         m_busy = 0;
         m_done = 0;
         m_ptr  = 0;
         m_miss = 0;
         m_prot = 0;
      end else begin
         if (bus.cnt_clr) begin
            m_miss = 0;
            m_prot = 0;
         end else if (hs) begin
            if (m_st == 2'b01 && m_miss < CMAX) m_miss++;
            if (m_st == 2'b10 && m_prot < CMAX) m_prot++;
         end
         if (m_busy && !m_done) begin
            m_done = 1;
            m_addr = '0;
            m_msel = 1'b0;
            if (bus.lk_multi) m_st = 2'b11;
            else if (|bus.lk_hit) begin
               m_st   = 2'b00;
               m_addr = bus.lk_out_addr;
               m_msel = bus.lk_master_sel;
            end else if (|bus.lk_prot) m_st = 2'b10;
            else m_st = 2'b01;
         end else if (hs) begin
            m_busy = 0;
            m_done = 0;
         end
         if (g) begin
            m_busy = 1;
            m_done = 0;
            m_who  = w;
            m_ptr  = (w + 1) % N;
            m_req  = '{bus.req_rw[w], bus.req_addr_min[w],
                       bus.req_addr_max[w]};
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_valid     = '0;
      bus.req_rw        = '0;
      bus.req_addr_min  = '0;
      bus.req_addr_max  = '0;
      bus.rsp_ready     = '1;
      bus.cfg_busy      = 1'b0;
      bus.cnt_clr       = 1'b0;
      bus.lk_hit        = '0;
      bus.lk_prot       = '0;
      bus.lk_multi      = 1'b0;
      bus.lk_master_sel = 1'b0;
      bus.lk_out_addr   = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(input int who);
      bit got;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.req_ready[who]) begin
            got = 1;
            step();
            bus.req_valid[who] = 1'b0;
            break;
         end
         step();
      end
      chk("grant_wait", 64'(got), 64'(1));
   endtask

   task automatic wait_rsp(input int who);
      bit got;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rsp_valid[who]) begin
            got = 1;
            break;
         end
         step();
      end
      chk("rsp_wait", 64'(got), 64'(1));
   endtask

   task automatic one_lookup(input int who, input logic [AW-1:0] mn,
                             input logic [E-1:0] hit,
                             input logic [E-1:0] prot,
                             input logic multi);
      bus.req_rw[who]       = 1'b1;
      bus.req_addr_min[who] = mn;
      bus.req_addr_max[who] = mn + 32'hFF;
      bus.req_valid[who]    = 1'b1;
      bus.lk_hit            = hit;
      bus.lk_prot           = prot;
      bus.lk_multi          = multi;
      bus.lk_out_addr       = 32'hDEAD_BEEF;
      bus.lk_master_sel     = 1'b1;
      wait_grant(who);
      wait_rsp(who);
   endtask

   int gq[$];
   int cq[$];

   initial begin
      idle_inputs();
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("rst_rsp_addr", 64'(bus.rsp_addr), 64'(0));
      chk("rst_rsp_status", 64'(bus.rsp_status), 64'(0));
      chk("rst_rsp_msel", 64'(bus.rsp_master_sel), 64'(0));
      chk("rst_lk_min", 64'(bus.lk_addr_min), 64'(0));
      chk("rst_idle", 64'(bus.sched_idle), 64'(1));
      step();

      // Single OK lookup
      bus.req_valid[0]    = 1'b1;
      bus.req_rw[0]       = 1'b0;
      bus.req_addr_min[0] = 32'h0000_1000;
      bus.req_addr_max[0] = 32'h0000_103F;
      bus.lk_hit          = 16'h0008;
      bus.lk_out_addr     = 32'h8000_1000;
      bus.lk_master_sel   = 1'b1;
      @(negedge clk);
      chk("t1_ready_c0", 64'(bus.req_ready), 64'(4'b0001));
      step();
      bus.req_valid = '0;
      @(negedge clk);
      chk("t1_lk_min", 64'(bus.lk_addr_min), 64'(32'h1000));
      chk("t1_lk_max", 64'(bus.lk_addr_max), 64'(32'h103F));
      chk("t1_no_rsp_c1", 64'(bus.rsp_valid), 64'(0));
      step();
      @(negedge clk);
      chk("t1_rsp_c2", 64'(bus.rsp_valid), 64'(4'b0001));
      chk("t1_addr", 64'(bus.rsp_addr), 64'(32'h8000_1000));
      chk("t1_msel", 64'(bus.rsp_master_sel), 64'(1));
      chk("t1_status", 64'(bus.rsp_status), 64'(2'b00));
      step();

      // Fairness
      idle_inputs();
      do_reset();
      bus.req_valid = 4'hF;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int j = 0; j < N; j++)
            if (bus.req_ready[j]) begin
               gq.push_back(j);
               cq.push_back(c);
            end
         step();
      end
      bus.req_valid = '0;
      chk("t2_ngrants", 64'(gq.size()), 64'(5));
      for (int k = 0; k < gq.size(); k++) begin
         chk("t2_order", 64'(gq[k]), 64'(k % N));
         chk("t2_cycle", 64'(cq[k]), 64'(2 * k));
      end
      repeat (3) step();

      // Classification
      idle_inputs();
      do_reset();
      one_lookup(0, 32'h2000, 16'h0000, 16'h0000, 1'b0);
      chk("t3a_status", 64'(bus.rsp_status), 64'(2'b01));
      chk("t3a_addr", 64'(bus.rsp_addr), 64'(0));
      step();
      @(negedge clk);
      chk("t3a_miss_cnt", 64'(bus.miss_cnt), 64'(1));
      step();
      one_lookup(1, 32'h3000, 16'h0000, 16'h0020, 1'b0);
      chk("t3b_status", 64'(bus.rsp_status), 64'(2'b10));
      step();
      @(negedge clk);
      chk("t3b_prot_cnt", 64'(bus.prot_cnt), 64'(1));
      step();
      one_lookup(2, 32'h4000, 16'h0011, 16'h0000, 1'b1);
      chk("t3c_status", 64'(bus.rsp_status), 64'(2'b11));
      chk("t3c_addr", 64'(bus.rsp_addr), 64'(0));
      step();

      // Backpressure then back-to-back grant
      idle_inputs();
      do_reset();
      bus.rsp_ready       = 4'b1101;
      bus.req_addr_min[1] = 32'h5000;
      bus.req_valid[1]    = 1'b1;
      bus.lk_hit          = 16'h0100;
      bus.lk_out_addr     = 32'h1234_5678;
      wait_grant(1);
      bus.req_valid[2] = 1'b1;
      wait_rsp(1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("t4_hold_valid", 64'(bus.rsp_valid), 64'(4'b0010));
         chk("t4_hold_addr", 64'(bus.rsp_addr), 64'(32'h1234_5678));
         chk("t4_hold_status", 64'(bus.rsp_status), 64'(0));
         chk("t4_no_grant", 64'(bus.req_ready), 64'(0));
         step();
      end
      bus.rsp_ready[1] = 1'b1;
      @(negedge clk);
      chk("t4_b2b_grant", 64'(bus.req_ready), 64'(4'b0100));
      step();
      bus.req_valid = '0;
      wait_rsp(2);
      step();

      // cfg_busy raised during LOOKUP
      idle_inputs();
      do_reset();
      bus.req_valid[3] = 1'b1;
      bus.lk_hit       = 16'h0001;
      bus.lk_out_addr  = 32'hCAFE_0000;
      wait_grant(3);
      bus.cfg_busy     = 1'b1;
      bus.req_valid[0] = 1'b1;
      wait_rsp(3);
      chk("t5_rsp_addr", 64'(bus.rsp_addr), 64'(32'hCAFE_0000));
      step();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t5_blocked", 64'(bus.req_ready), 64'(0));
         chk("t5_idle", 64'(bus.sched_idle), 64'(1));
         step();
      end
      bus.cfg_busy = 1'b0;
      @(negedge clk);
      chk("t5_release", 64'(bus.req_ready), 64'(4'b0001));
      step();
      bus.req_valid = '0;
      wait_rsp(0);
      step();

      // Miss counter saturation, then clear against a miss
      idle_inputs();
      do_reset();
      bus.req_valid[1] = 1'b1;
      repeat (540) step();
      @(negedge clk);
      chk("t6_sat", 64'(bus.miss_cnt), 64'(CMAX));
      for (int k = 0; k < 3; k++) begin
         if (bus.rsp_valid != 0) break;
         step();
         @(negedge clk);
      end
      step();
      step();
      bus.cnt_clr = 1'b1;
      @(negedge clk);
      chk("t6_clr_on_hs", 64'(bus.rsp_valid), 64'(4'b0010));
      step();
      bus.cnt_clr   = 1'b0;
      bus.req_valid = '0;
      @(negedge clk);
      chk("t6_clr", 64'(bus.miss_cnt), 64'(0));
      repeat (3) step();

      // Reset while holding a response
      idle_inputs();
      do_reset();
      bus.rsp_ready    = '0;
      bus.req_valid[2] = 1'b1;
      wait_grant(2);
      wait_rsp(2);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_rst_valid", 64'(bus.rsp_valid), 64'(0));
      chk("t6_rst_idle", 64'(bus.sched_idle), 64'(1));
      step();
      bus.rsp_ready = '1;
      bus.req_valid = 4'hF;
      @(negedge clk);
      chk("t6_rst_ptr", 64'(bus.req_ready), 64'(4'b0001));
      step();
      bus.req_valid = '0;
      repeat (3) step();

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         bus.req_valid = N'($urandom) & N'($urandom);
         for (int i = 0; i < N; i++) begin
            bus.req_rw[i]       = 1'($urandom);
            bus.req_addr_min[i] = AW'($urandom);
            bus.req_addr_max[i] = bus.req_addr_min[i] + AW'($urandom_range(0, 4095));
         end
         bus.rsp_ready     = N'($urandom);
         bus.cfg_busy      = ($urandom_range(0, 9) == 0);
         bus.cnt_clr       = ($urandom_range(0, 79) == 0);
         rst_n             = ($urandom_range(0, 399) != 0);
         bus.lk_hit        = ($urandom_range(0, 1) == 0) ? '0 : E'($urandom);
         bus.lk_prot       = ($urandom_range(0, 1) == 0) ? '0 : E'($urandom);
         bus.lk_multi      = ($urandom_range(0, 5) == 0);
         bus.lk_master_sel = 1'($urandom);
         bus.lk_out_addr   = AW'($urandom);
         step();
      end
      idle_inputs();
      rst_n = 1'b1;
      repeat (4) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
